ram_arbiter: RTL and testbench

//   Shares the single-port word RAM between instruction fetch (imem) and load/store (dmem).
//   RAM has a combinational read and a posedge write with byte enables.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 35 +++
 rtl/arb_starve_counter.sv | 29 ++
 rtl/ram_arbiter.sv | 99 +++++++++
 tb/tb_ram_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter slice.
package ram_arbiter_pkg;

    // Owner of the response that is due in the current cycle.
    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_INSTR,
        RESP_DATA_RD,
        RESP_DATA_WR
    } mem_resp_owner_t;

    localparam int unsigned WORD_W = 32;

    // Word-aligns a byte address; the RAM ignores the low two bits.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU-side fetch/load-store ports plus the RAM port of the arbiter.
interface ram_arbiter_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        ram_we;
    logic [31:0] ram_a;
    logic [31:0] ram_wd;
    logic [3:0]  ram_be;
    logic [31:0] ram_rd;

    // Core and RAM side (environment around the arbiter).
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ram_rd,
        input  imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
               ram_we, ram_a, ram_wd, ram_be
    );

    // Arbiter side.
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ram_rd,
        output imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid, dmem_rdata,
               ram_we, ram_a, ram_wd, ram_be
    );
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive dmem wins while a fetch is waiting.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    // LIMIT=0 still needs a 1-bit register; it never leaves zero.
    localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Count up to LIM and hold there until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (LIMIT != 0) && (cnt == LIM);
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch and load/store; data side has
// priority, bounded by a starvation limit for fetches.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   bus
);
    logic            starve_hit;
    logic            imem_gnt_w;
    logic            dmem_gnt_w;
    logic            starve_inc;
    logic            starve_clr;
    mem_resp_owner_t resp_owner;
    mem_resp_owner_t resp_next;
    logic [31:0]     imem_rdata_q;
    logic [31:0]     dmem_rdata_q;

    // Grant selection; both grants held low during reset.
    always_comb begin
        dmem_gnt_w = rst_n && bus.dmem_req && !(bus.imem_req && starve_hit);
        imem_gnt_w = rst_n && bus.imem_req && !dmem_gnt_w;
        starve_inc = dmem_gnt_w && bus.imem_req;
        starve_clr = imem_gnt_w || !bus.imem_req;
    end

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .hit   (starve_hit)
    );

    // RAM port mux driven by the current winner.
    always_comb begin
        bus.imem_gnt = imem_gnt_w;
        bus.dmem_gnt = dmem_gnt_w;
        bus.ram_we   = dmem_gnt_w && bus.dmem_we;
        bus.ram_a    = '0;
        bus.ram_be   = '0;
        bus.ram_wd   = rst_n ? bus.dmem_wdata : '0;
        if (dmem_gnt_w) begin
            bus.ram_a  = word_align(bus.dmem_addr);
            bus.ram_be = bus.dmem_be;
        end else if (imem_gnt_w) begin
            bus.ram_a  = word_align(bus.imem_addr);
            bus.ram_be = bus.dmem_be;
        end
    end

    // Response owner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= RESP_NONE;
        end else begin
            resp_owner <= resp_next;
        end
    end

    // Next response owner from this cycle's grant; rvalids decode the owner.
    always_comb begin
        resp_next       = RESP_NONE;
        bus.imem_rvalid = 1'b0;
        bus.dmem_rvalid = 1'b0;
        if (imem_gnt_w) begin
            resp_next = RESP_INSTR;
        end else if (dmem_gnt_w) begin
            resp_next = bus.dmem_we ? RESP_DATA_WR : RESP_DATA_RD;
        end
        case (resp_owner)
            RESP_INSTR:   bus.imem_rvalid = 1'b1;
            RESP_DATA_RD: bus.dmem_rvalid = 1'b1;
            RESP_DATA_WR: bus.dmem_rvalid = 1'b1;
            default:      ;
        endcase
    end

    // Read data captured at the grant edge and held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            if (imem_gnt_w) begin
                imem_rdata_q <= bus.ram_rd;
            end
            if (dmem_gnt_w && !bus.dmem_we) begin
                dmem_rdata_q <= bus.ram_rd;
            end
        end
    end

    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus multi-cycle sequences.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter_if b0();
    ram_arbiter_if b1();

    ram_arbiter #(.STARVE_LIMIT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    ram_arbiter #(.STARVE_LIMIT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Word RAM behind dut0: combinational read, byte-enabled posedge write.
    logic [31:0] mem [0:63];
    assign b0.ram_rd = mem[b0.ram_a[7:2]];
    always @(posedge clk) begin
        if (b0.ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b0.ram_be[i]) mem[b0.ram_a[7:2]][8*i +: 8] <= b0.ram_wd[8*i +: 8];
            end
        end
    end
    assign b1.ram_rd = 32'h5A5A_5A5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        egi;
        logic        egd;
        logic        ewe;
        logic [31:0] ea;
        logic        eirv;
        logic        edrv;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t vt [6];

    task automatic idle0();
        b0.imem_req = 0; b0.imem_addr = '0; b0.dmem_req = 0; b0.dmem_we = 0;
        b0.dmem_addr = '0; b0.dmem_wdata = '0; b0.dmem_be = '0;
    endtask

    initial begin
        int ig_cnt;
        int dg_cnt;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h0000_0013;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'hCAFE_F00D;

        //            ireq iaddr        dreq dwe daddr        dwdata         dbe      egi egd ewe ea           eirv edrv eird           edrd
        vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h13,        32'h0};
        vt[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'hAABBCCDD,  4'b0011, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 32'h13,        32'h0};
        vt[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h13,        32'h1122CCDD};
        vt[3] = '{1'b1, 32'h30, 1'b1, 1'b0, 32'h33, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0, 32'h30, 1'b0, 1'b1, 32'h13,        32'hCAFEF00D};
        vt[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,         4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h13,        32'hCAFEF00D};
        vt[5] = '{1'b1, 32'h21, 1'b0, 1'b0, 32'h0,  32'h0,         4'b0000, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h1122CCDD,  32'hCAFEF00D};

        // Reset with both requests asserted.
        rst_n = 1'b0;
        b0.imem_req = 1; b0.imem_addr = 32'h10; b0.dmem_req = 1; b0.dmem_we = 1;
        b0.dmem_addr = 32'h0; b0.dmem_wdata = 32'hFFFF_FFFF; b0.dmem_be = 4'b0000;
        b1.imem_req = 0; b1.imem_addr = '0; b1.dmem_req = 0; b1.dmem_we = 0;
        b1.dmem_addr = '0; b1.dmem_wdata = '0; b1.dmem_be = '0;
        repeat (2) @(negedge clk);
        chk("rst_imem_gnt", 32'(b0.imem_gnt), 0);
        chk("rst_dmem_gnt", 32'(b0.dmem_gnt), 0);
        chk("rst_ram_we", 32'(b0.ram_we), 0);
        chk("rst_rvalids", {30'b0, b0.imem_rvalid, b0.dmem_rvalid}, 0);
        chk("rst_ram_a", b0.ram_a, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_dmem_gnt", 32'(b0.dmem_gnt), 1);
        chk("post_rst_imem_gnt", 32'(b0.imem_gnt), 0);
        @(negedge clk);
        idle0();
        @(negedge clk);

        // Table-driven single-cycle transactions.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b0.imem_req = vt[i].ireq; b0.imem_addr = vt[i].iaddr;
            b0.dmem_req = vt[i].dreq; b0.dmem_we = vt[i].dwe; b0.dmem_addr = vt[i].daddr;
            b0.dmem_wdata = vt[i].dwdata; b0.dmem_be = vt[i].dbe;
            #1;
            chk($sformatf("v%0d_imem_gnt", i), 32'(b0.imem_gnt), 32'(vt[i].egi));
            chk($sformatf("v%0d_dmem_gnt", i), 32'(b0.dmem_gnt), 32'(vt[i].egd));
            chk($sformatf("v%0d_ram_we", i), 32'(b0.ram_we), 32'(vt[i].ewe));
            chk($sformatf("v%0d_ram_a", i), b0.ram_a, vt[i].ea);
            @(posedge clk);
            #1;
            idle0();
            chk($sformatf("v%0d_imem_rvalid", i), 32'(b0.imem_rvalid), 32'(vt[i].eirv));
            chk($sformatf("v%0d_dmem_rvalid", i), 32'(b0.dmem_rvalid), 32'(vt[i].edrv));
            chk($sformatf("v%0d_imem_rdata", i), b0.imem_rdata, vt[i].eird);
            chk($sformatf("v%0d_dmem_rdata", i), b0.dmem_rdata, vt[i].edrd);
        end
        @(negedge clk);

        // Both requests held: D,D,D,D,I repeating.
        b0.imem_req = 1; b0.imem_addr = 32'h10; b0.dmem_req = 1; b0.dmem_addr = 32'h30;
        for (int c = 0; c < 13; c++) begin
            #1;
            chk($sformatf("starve_c%0d_imem_gnt", c), 32'(b0.imem_gnt), (c % 5 == 4) ? 1 : 0);
            chk($sformatf("starve_c%0d_dmem_gnt", c), 32'(b0.dmem_gnt), (c % 5 == 4) ? 0 : 1);
            @(negedge clk);
        end
        // Last cycle above was a dmem grant with fetch still waiting; drop both.
        idle0();
        #1;
        chk("drop_dmem_rvalid", 32'(b0.dmem_rvalid), 1);
        chk("drop_imem_rvalid", 32'(b0.imem_rvalid), 0);
        @(negedge clk);
        chk("drop_idle_rvalids", {30'b0, b0.imem_rvalid, b0.dmem_rvalid}, 0);

        // Strict priority instance: fetch never granted.
        b1.imem_req = 1; b1.imem_addr = 32'h40; b1.dmem_req = 1; b1.dmem_addr = 32'h80;
        ig_cnt = 0; dg_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (b1.imem_gnt) ig_cnt++;
            if (b1.dmem_gnt) dg_cnt++;
            @(negedge clk);
        end
        chk("strict_imem_gnt_count", ig_cnt, 0);
        chk("strict_dmem_gnt_count", dg_cnt, 20);
        b1.imem_req = 0; b1.dmem_req = 0;

        // Reset in the response cycle of a load drops the response.
        b0.dmem_req = 1; b0.dmem_we = 0; b0.dmem_addr = 32'h10;
        @(posedge clk);
        #1;
        idle0();
        chk("pre_rst_dmem_rvalid", 32'(b0.dmem_rvalid), 1);
        chk("pre_rst_dmem_rdata", b0.dmem_rdata, 32'h13);
        rst_n = 1'b0;
        #1;
        chk("async_rst_dmem_rvalid", 32'(b0.dmem_rvalid), 0);
        chk("async_rst_dmem_rdata", b0.dmem_rdata, 0);
        chk("async_rst_imem_rdata", b0.imem_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst_rvalids", {30'b0, b0.imem_rvalid, b0.dmem_rvalid}, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
